multdiv_ctrl: RTL and testbench
===============================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_STEPS, default 16, giving the number of iteration cycles for a multiply.
REQ-002 The block SHALL have parameter DIV_STEPS, default 32, giving the number of iteration cycles for a divide; both parameters are in the range 1..63.
REQ-003 Port clock  in  1  single system clock, all state updates on the rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port ctrl_mult  in  1  start-multiply request from the decode/ALU stage, sampled in IDLE or DONE.
REQ-006 Port ctrl_div  in  1  start-divide request, sampled in IDLE or DONE.
REQ-007 Port flush  in  1  abandon any operation in progress (branch or jump taken).
REQ-008 Port dp_zero_divisor  in  1  datapath flag: latched divisor equals zero, valid in the INIT cycle.
REQ-009 Port dp_init  out  1  load operands into the iterative datapath.
REQ-010 Port dp_step  out  1  advance the datapath by one iteration.
REQ-011 Port dp_mode  out  1  0 = multiply, 1 = divide; latched at start.
REQ-012 Port step_count  out  6  index of the current iteration.
REQ-013 Port stall  out  1  hold the upstream pipeline.
REQ-014 Port busy  out  1  high in INIT and RUN.
REQ-015 Port data_resultRDY  out  1  one-cycle result-valid pulse.
REQ-016 Port data_exception  out  1  divide-by-zero flag, valid with data_resultRDY.
REQ-017 Port weStatus  out  1  status-register write enable, equal to data_exception.

Function
REQ-018 The FSM SHALL have the states IDLE, INIT, RUN and DONE.
REQ-019 Start SHALL be defined as (ctrl_mult | ctrl_div) & ~flush, sampled in IDLE or DONE; when both requests are high, multiply wins and dp_mode is set to 0.
REQ-020 On start in IDLE or DONE: next state INIT, dp_mode latched, exception flag cleared.
REQ-021 INIT SHALL assert dp_init for exactly one cycle.
REQ-022 INIT exit: if dp_mode=1 and dp_zero_divisor=1, go to DONE with exception flag set; otherwise go to RUN with step_count=0.
REQ-023 RUN SHALL assert dp_step every cycle and increment step_count each cycle.
REQ-024 RUN exit: go to DONE when step_count == STEPS-1, where STEPS is MULT_STEPS or DIV_STEPS per dp_mode; step_count holds its value in DONE.
REQ-025 DONE SHALL assert data_resultRDY=1 for one cycle, with data_exception and weStatus equal to the exception flag.
REQ-026 DONE exit: next state IDLE, or INIT on a start (back-to-back issue with no idle cycle).
REQ-027 stall SHALL be (state==INIT | state==RUN) | (state in {IDLE,DONE} & start), combinational, so it asserts in the same cycle as the request and is 0 in the DONE cycle unless a new start occurs there.
REQ-028 busy SHALL be high exactly in INIT and RUN.
REQ-029 dp_init, dp_step, data_resultRDY, data_exception and weStatus SHALL be 0 in every state other than those named above.
REQ-030 Latency, with the start accepted in cycle T: data_resultRDY in cycle T+2+STEPS; multiply at defaults = T+18, divide = T+34, divide by zero = T+2.
REQ-031 flush in any state SHALL force next state IDLE with no data_resultRDY and no weStatus; flush has priority over a same-cycle start and over the DONE pulse of the following cycle.
REQ-032 ctrl_mult and ctrl_div asserted during INIT or RUN SHALL be ignored.
REQ-033 dp_zero_divisor SHALL be ignored outside INIT and for multiply.

Reset
REQ-034 While reset=0: state IDLE, step_count=0, dp_mode=0, exception flag=0, and all outputs 0 (stall=0 regardless of requests), asynchronously.
REQ-035 Deassertion of reset mid-operation SHALL resume from IDLE; no result pulse is produced for the interrupted operation.

Verification
REQ-036 ctrl_mult pulse at T (defaults) -> stall=1 in T..T+17, dp_init at T+1, dp_step in T+2..T+17, data_resultRDY=1 only at T+18, data_exception=0.
REQ-037 ctrl_div pulse with dp_zero_divisor=1 -> dp_init at T+1, no dp_step, data_resultRDY=data_exception=weStatus=1 at T+2, stall=0 at T+2.
REQ-038 ctrl_div with a nonzero divisor, flush=1 at T+10 -> IDLE at T+11, no data_resultRDY through T+40, stall=0 from T+11.
REQ-039 ctrl_mult and ctrl_div together at T -> dp_mode=0, data_resultRDY at T+18; a ctrl_div at T+18 -> INIT at T+19, dp_mode=1, data_resultRDY at T+52.
REQ-040 reset=0 at T+5 during a multiply -> all outputs 0 immediately; after release, no data_resultRDY without a new start.

Source files
------------

// File: rtl/multdiv_ctrl_if.sv
// Request and datapath handshake bundle for the multiply/divide controller.
// master: pipeline/datapath side; slave: controller side.
interface multdiv_ctrl_if;
    logic       ctrl_mult;
    logic       ctrl_div;
    logic       flush;
    logic       dp_zero_divisor;
    logic       dp_init;
    logic       dp_step;
    logic       dp_mode;
    logic [5:0] step_count;
    logic       stall;
    logic       busy;
    logic       data_resultRDY;
    logic       data_exception;
    logic       weStatus;

    modport master (
        output ctrl_mult, ctrl_div, flush, dp_zero_divisor,
        input  dp_init, dp_step, dp_mode, step_count,
        input  stall, busy, data_resultRDY, data_exception, weStatus
    );

    modport slave (
        input  ctrl_mult, ctrl_div, flush, dp_zero_divisor,
        output dp_init, dp_step, dp_mode, step_count,
        output stall, busy, data_resultRDY, data_exception, weStatus
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for an iterative multiply/divide datapath: IDLE/INIT/RUN/DONE.
// Ports: clock, reset (async active-low), bus (multdiv_ctrl_if.slave).
module multdiv_ctrl #(
    parameter int unsigned MULT_STEPS = 16,
    parameter int unsigned DIV_STEPS  = 32
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } state_t;

    localparam logic [5:0] MULT_LAST = 6'(MULT_STEPS - 1);
    localparam logic [5:0] DIV_LAST  = 6'(DIV_STEPS - 1);

    state_t     state_q, state_d;
    logic [5:0] step_q, step_d;
    logic       mode_q, mode_d;
    logic       exc_q, exc_d;

    logic       start;
    logic       accept;
    logic [5:0] last_step;

    assign start     = (bus.ctrl_mult | bus.ctrl_div) & ~bus.flush;
    assign accept    = (state_q == IDLE || state_q == DONE) & start;
    assign last_step = mode_q ? DIV_LAST : MULT_LAST;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            mode_q  <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        mode_d  = mode_q;
        exc_d   = exc_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = INIT;
                        // multiply wins when both requests arrive together
                        mode_d  = ~bus.ctrl_mult;
                        exc_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                INIT: begin
                    if (mode_q && bus.dp_zero_divisor) begin
                        state_d = DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        step_d  = '0;
                    end
                end
                RUN: begin
                    // step_count stays on the last index through DONE
                    if (step_q == last_step) begin
                        state_d = DONE;
                    end else begin
                        step_d = step_q + 6'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.dp_init        = (state_q == INIT);
    assign bus.dp_step        = (state_q == RUN);
    assign bus.busy           = (state_q == INIT) | (state_q == RUN);
    assign bus.dp_mode        = mode_q;
    assign bus.step_count     = step_q;
    assign bus.data_resultRDY = (state_q == DONE);
    assign bus.data_exception = (state_q == DONE) & exc_q;
    assign bus.weStatus       = (state_q == DONE) & exc_q;
    // reset gates the combinational request path so stall drops at once
    assign bus.stall          = reset & (bus.busy | accept);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a result scoreboard.
// Expected result cycles are queued at issue and matched on data_resultRDY.
module tb_multdiv_ctrl;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int n_assert;
    int n_fail;

    typedef struct {
        int unsigned at;
        logic        exc;
    } exp_t;

    exp_t sb[$];

    multdiv_ctrl_if bus ();

    multdiv_ctrl dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    // scoreboard: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_resultRDY) begin
                if (sb.size() == 0) begin
                    chkn("unexpected_rdy", int'(cyc), -1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chkn("rdy_cycle", int'(cyc), int'(e.at));
                    chk1("rdy_exception", bus.data_exception, e.exc);
                    chk1("rdy_westatus", bus.weStatus, e.exc);
                end
            end else if (sb.size() != 0 && cyc > sb[0].at) begin
                chkn("missing_rdy", int'(cyc), int'(sb[0].at));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic m, input logic d,
                         input logic f, input logic z);
        bus.ctrl_mult       = m;
        bus.ctrl_div        = d;
        bus.flush           = f;
        bus.dp_zero_divisor = z;
    endtask

    initial begin
        int unsigned t;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // reset holds everything low, even with a request pending
        repeat (2) @(negedge clk);
        chk1("rst_stall", bus.stall, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chkn("rst_step", int'(bus.step_count), 0);
        chk1("rst_mode", bus.dp_mode, 1'b0);
        chk1("rst_rdy", bus.data_resultRDY, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // multiply, request held into INIT/RUN where it must be ignored
        chk1("idle_stall", bus.stall, 1'b0);
        t = cyc;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back('{at: t + 18, exc: 1'b0});
        #1 chk1("mul_stall_T", bus.stall, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk1("mul_stall", bus.stall, k <= 17);
            chk1("mul_init", bus.dp_init, k == 1);
            chk1("mul_step", bus.dp_step, k >= 2 && k <= 17);
            chk1("mul_busy", bus.busy, k <= 17);
            chk1("mul_mode", bus.dp_mode, 1'b0);
            if (k >= 2)
                chkn("mul_count", int'(bus.step_count),
                     (k <= 17) ? k - 2 : 15);
            if (k == 3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk1("mul_idle_busy", bus.busy, 1'b0);

        // divide by zero: straight from INIT to DONE with exception
        t = cyc;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        sb.push_back('{at: t + 2, exc: 1'b1});
        @(negedge clk);
        chk1("dz_init", bus.dp_init, 1'b1);
        chk1("dz_mode", bus.dp_mode, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk1("dz_step", bus.dp_step, 1'b0);
        chk1("dz_rdy", bus.data_resultRDY, 1'b1);
        chk1("dz_exc", bus.data_exception, 1'b1);
        chk1("dz_stall", bus.stall, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // divide flushed mid-run: no result ever appears
        t = cyc;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        chk1("fl_busy_T10", bus.busy, 1'b1);
        chkn("fl_count_T10", int'(bus.step_count), 8);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 11; k <= 40; k++) begin
            chk1("fl_stall", bus.stall, 1'b0);
            chk1("fl_rdy", bus.data_resultRDY, 1'b0);
            @(negedge clk);
        end

        // both requests: multiply wins; divide issued back-to-back in DONE
        t = cyc;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        sb.push_back('{at: t + 18, exc: 1'b0});
        @(negedge clk);
        chk1("bb_mode_mul", bus.dp_mode, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        chk1("bb_done", bus.data_resultRDY, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        sb.push_back('{at: t + 52, exc: 1'b0});
        #1 chk1("bb_done_stall", bus.stall, 1'b1);
        @(negedge clk);
        chk1("bb_init", bus.dp_init, 1'b1);
        chk1("bb_mode_div", bus.dp_mode, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (33) @(negedge clk);
        chkn("bb_at52", int'(cyc - t), 52);
        chk1("bb_rdy52", bus.data_resultRDY, 1'b1);
        chkn("bb_count", int'(bus.step_count), 31);
        @(negedge clk);

        // reset during a multiply: outputs drop at once, no stale result
        t = cyc;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk1("rm_busy_pre", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rm_stall", bus.stall, 1'b0);
        chk1("rm_busy", bus.busy, 1'b0);
        chk1("rm_step", bus.dp_step, 1'b0);
        chkn("rm_count", int'(bus.step_count), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            chk1("rm_idle", bus.busy, 1'b0);
        end

        repeat (3) @(negedge clk);
        chkn("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
